aes_inv_mixcol_iter: RTL and testbench

Iterative AES InvMixColumns engine for the decryption datapath. It is the inverse of the MixColumns stage in the encryption rounds. It accepts a 128-bit AES state over a valid/ready handshake and transforms one or more columns per cycle with a shared GF(2^8) column unit. It then holds the result until the downstream round logic takes it.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_inv_mixcol_col.sv | 21 ++
 rtl/aes_inv_mixcol_iter.sv | 97 +++++++++
 tb/tb_aes_inv_mixcol_iter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state type for the InvMixColumns engine and the
// GF(2^8) multiply helpers built from an xtime chain (reused by forward MixColumns).
package aes_pkg;

    localparam int AES_NB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } inv_mc_state_t;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = gf_xtime(b);
        x4 = gf_xtime(x2);
        x8 = gf_xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/aes_inv_mixcol_col.sv
// Combinational InvMixColumns transform of one 32-bit column (byte 0 in the MSBs).
module aes_inv_mixcol_col
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
    assign col_out[23:16] = gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3) ^ gf_mul9(a0);
    assign col_out[15:8]  = gf_mule(a2) ^ gf_mulb(a3) ^ gf_muld(a0) ^ gf_mul9(a1);
    assign col_out[7:0]   = gf_mule(a3) ^ gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2);

endmodule

// File: rtl/aes_inv_mixcol_iter.sv
// Iterative InvMixColumns engine: captures a state, transforms COLS_PER_CYCLE
// columns per cycle in place, then holds the result until downstream takes it.
module aes_inv_mixcol_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy,
    output logic [1:0]   state_dbg
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_inv_mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // cnt wraps to 0 after the final group, so the last group starts at AES_NB-COLS_PER_CYCLE.
    localparam logic [1:0] LAST_CNT = 2'(AES_NB - COLS_PER_CYCLE);
    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);

    inv_mc_state_t state;
    logic [127:0]  work;
    logic [1:0]    cnt;
    logic [1:0]    col_idx [COLS_PER_CYCLE];
    logic [31:0]   col_in  [COLS_PER_CYCLE];
    logic [31:0]   col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = cnt + 2'(g);
        assign col_in[g]  = work[127 - 32*int'(col_idx[g]) -: 32];

        aes_inv_mixcol_col u_col (
            .col_in  (col_in[g]),
            .col_out (col_out[g])
        );
    end

    assign out_state = work;
    assign state_dbg = state;

    // Handshake: a transfer happens only on a rising edge where valid and ready
    // are both high; in_ready/out_valid are registered, so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            work      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work     <= in_state;
                        cnt      <= '0;
                        state    <= ST_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        work[127 - 32*int'(col_idx[g]) -: 32] <= col_out[g];
                    end
                    cnt <= cnt + CNT_STEP;
                    if (cnt == LAST_CNT) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_mixcol_iter.sv
// Directed bench for aes_inv_mixcol_iter: FIPS vectors, all COLS_PER_CYCLE values,
// backpressure, streaming, reset mid-operation and a MixColumns round trip.
module tb_aes_inv_mixcol_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_state = '0;
    logic         out_ready = 1'b0;

    logic         in_ready, out_valid, busy;
    logic [127:0] out_state;
    logic [1:0]   state_dbg;
    logic         in_ready2, out_valid2, busy2;
    logic [127:0] out_state2;
    logic [1:0]   state_dbg2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] out_state4;
    logic [1:0]   state_dbg4;

    int total = 0;
    int bad = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN    = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V2_OUT   = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;

    aes_inv_mixcol_iter #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .busy(busy), .state_dbg(state_dbg)
    );

    aes_inv_mixcol_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_state(in_state), .out_valid(out_valid2), .out_ready(out_ready),
        .out_state(out_state2), .busy(busy2), .state_dbg(state_dbg2)
    );

    aes_inv_mixcol_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_state(in_state), .out_valid(out_valid4), .out_ready(out_ready),
        .out_state(out_state4), .busy(busy4), .state_dbg(state_dbg4)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inverse);
        logic [127:0] r;
        logic [7:0]   a [4];
        logic [7:0]   k0, k1, k2, k3;
        r = '0;
        k0 = inverse ? 8'h0e : 8'h02;
        k1 = inverse ? 8'h0b : 8'h03;
        k2 = inverse ? 8'h0d : 8'h01;
        k3 = inverse ? 8'h09 : 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int b = 0; b < 4; b++) a[b] = s[127 - 32*c - 8*b -: 8];
            for (int b = 0; b < 4; b++) begin
                r[127 - 32*c - 8*b -: 8] = gmul(k0, a[b]) ^ gmul(k1, a[(b+1)%4])
                                         ^ gmul(k2, a[(b+2)%4]) ^ gmul(k3, a[(b+3)%4]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_and_wait(input logic [127:0] s, output logic [127:0] got, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        in_valid = 1'b1;
        in_state = s;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
        got = out_state;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (out_state !== 128'h0) begin bad++; $display("FAIL reset_out_state got=%h want=0", out_state); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    endtask

    task automatic test_all_cols();
        int lat1, lat2, lat4;
        do_reset();
        in_valid = 1'b1;
        in_state = V2_IN;
        step();
        in_valid = 1'b0;
        lat1 = -1; lat2 = -1; lat4 = -1;
        for (int c = 1; c <= 8; c++) begin
            if (out_valid4 && lat4 < 0) lat4 = c - 1;
            if (out_valid2 && lat2 < 0) lat2 = c - 1;
            if (out_valid && lat1 < 0) lat1 = c - 1;
            step();
        end
        total++; if (lat1 !== 4) begin bad++; $display("FAIL cols1_latency got=%0d want=4", lat1); end
        total++; if (lat2 !== 2) begin bad++; $display("FAIL cols2_latency got=%0d want=2", lat2); end
        total++; if (lat4 !== 1) begin bad++; $display("FAIL cols4_latency got=%0d want=1", lat4); end
        total++; if (out_state !== V2_OUT) begin bad++; $display("FAIL cols1_data got=%h want=%h", out_state, V2_OUT); end
        total++; if (out_state2 !== V2_OUT) begin bad++; $display("FAIL cols2_data got=%h want=%h", out_state2, V2_OUT); end
        total++; if (out_state4 !== V2_OUT) begin bad++; $display("FAIL cols4_data got=%h want=%h", out_state4, V2_OUT); end
        drain();
    endtask

    task automatic test_fips();
        logic [127:0] got;
        int lat;
        send_and_wait(FIPS_IN, got, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL fips_latency got=%0d want=4", lat); end
        total++; if (got !== FIPS_OUT) begin bad++; $display("FAIL fips_data got=%h want=%h", got, FIPS_OUT); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fips_busy_done got=%b want=1", busy); end
        total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL fips_state_done got=%0d want=2", state_dbg); end
        drain();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fips_valid_drop got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fips_ready_back got=%b want=1", in_ready); end
    endtask

    task automatic test_backpressure();
        logic [127:0] got;
        int lat;
        send_and_wait(V2_IN, got, lat);
        total++; if (got !== V2_OUT) begin bad++; $display("FAIL bp_data got=%h want=%h", got, V2_OUT); end
        in_valid = 1'b1;
        in_state = FIPS_IN;
        for (int i = 0; i < 10; i++) begin
            step();
            total++; if (out_state !== V2_OUT) begin bad++; $display("FAIL bp_hold_data cyc=%0d got=%h want=%h", i, out_state, V2_OUT); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, out_valid); end
        end
        in_valid = 1'b0;
        drain();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_no_accept got=%b want=0", busy); end
        total++; if (out_state !== V2_OUT) begin bad++; $display("FAIL bp_no_overwrite got=%h want=%h", out_state, V2_OUT); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vec [8];
        logic [127:0] exp_v;
        int cyc, prev, sent, got_n;
        logic acc, cmp;
        for (int i = 0; i < 8; i++) vec[i] = rand_state();
        exp_q.delete();
        cyc = 0; prev = -1; sent = 0; got_n = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_state = vec[0];
        while (got_n < 8 && cyc < 200) begin
            acc = in_valid && in_ready;
            cmp = out_valid && out_ready;
            if (cmp) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b2b_unexpected got=%h want=none", out_state);
                end else begin
                    exp_v = exp_q.pop_front();
                    total++; if (out_state !== exp_v) begin bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", got_n, out_state, exp_v); end
                end
                if (prev >= 0) begin
                    total++; if (cyc - prev !== 6) begin bad++; $display("FAIL b2b_interval got=%0d want=6", cyc - prev); end
                end
                prev = cyc;
                got_n++;
            end
            if (acc) begin
                exp_q.push_back(mix_model(in_state, 1'b1));
                sent++;
            end
            step();
            cyc++;
            if (acc) begin
                if (sent < 8) in_state = vec[sent];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++; if (got_n !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got_n); end
    endtask

    task automatic test_reset_mid_busy();
        logic [127:0] got;
        int lat;
        in_valid = 1'b1;
        in_state = rand_state();
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_busy_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy_busy got=%b want=0", busy); end
        total++; if (out_state !== 128'h0) begin bad++; $display("FAIL rst_busy_out_state got=%h want=0", out_state); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_busy_in_ready got=%b want=1", in_ready); end
        #2;
        rst_n = 1'b1;
        step();
        send_and_wait(FIPS_IN, got, lat);
        total++; if (got !== FIPS_OUT) begin bad++; $display("FAIL rst_busy_next got=%h want=%h", got, FIPS_OUT); end
        total++; if (lat !== 4) begin bad++; $display("FAIL rst_busy_latency got=%0d want=4", lat); end
        drain();
    endtask

    task automatic test_round_trip();
        logic [127:0] x, got;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            x = rand_state();
            send_and_wait(mix_model(x, 1'b0), got, lat);
            total++; if (got !== x || lat !== 4) begin bad++; $display("FAIL round_trip idx=%0d got=%h lat=%0d want=%h lat=4", i, got, lat, x); end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_all_cols();
        test_fips();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
